control_sequencer: RTL and testbench

Hardwired control unit for the ArithmeticLogicUnitSystem datapath. Each instruction is fetched from memory as two bytes into the instruction register (IR) and decoded from `IROut`. The unit then drives every datapath control input for one or two execute cycles. It sits directly upstream of the datapath: its outputs connect one-to-one to the datapath control ports, and its only datapath inputs are `IROut` and `FlagsOut`.

---
 rtl/control_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit: two-byte instruction fetch into IR, then one or two
// execute cycles decoded from IROut that drive every datapath control input.
module control_sequencer #(
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  FlagsOut,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [1:0]  MuxCSel,
  output logic        MuxDSel,
  output logic [1:0]  DR_FunSel,
  output logic        DR_E,
  output logic [2:0]  SeqState,
  output logic        Halted
);

  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_HALT = 3'd4
  } state_e;

  localparam logic [5:0] OP_BRA = 6'h00;
  localparam logic [5:0] OP_BNE = 6'h01;
  localparam logic [5:0] OP_IMM = 6'h02;
  localparam logic [5:0] OP_ADD = 6'h03;
  localparam logic [5:0] OP_STB = 6'h04;

  state_e state_q, state_d;

  logic [5:0] opcode;
  logic [1:0] rx, ry;
  logic       flag_z;
  logic       unused_ir_bits;

  assign opcode         = IROut[15:10];
  assign rx             = IROut[9:8];
  assign ry             = IROut[1:0];
  assign flag_z         = FlagsOut[3];
  assign unused_ir_bits = ^{IROut[7:2], FlagsOut[2:0]};

  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_T0;
    else       state_q <= state_d;
  end

  assign SeqState = state_q;

  // NOTE: every output and state_d gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 3'b000;
    RF_RegSel   = 4'b0000;
    RF_ScrSel   = 4'b0000;
    ALU_FunSel  = 5'b00000;
    ALU_WF      = 1'b0;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = 3'b000;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 2'b00;
    MuxDSel     = 1'b0;
    DR_FunSel   = 2'b00;
    DR_E        = 1'b0;
    Halted      = 1'b0;

    case (state_q)
      S_T0, S_T1: begin
        ARF_OutDSel = 2'b00;
        Mem_CS      = 1'b0;
        Mem_WR      = 1'b0;
        IR_Write    = 1'b1;
        IR_LH       = (state_q == S_T1);
        ARF_RegSel  = 3'b100;
        ARF_FunSel  = 2'b01;
        state_d     = (state_q == S_T0) ? S_T1 : S_T2;
      end

      S_T2: begin
        state_d = S_T0;
        if (opcode == HALT_OPCODE) begin
          state_d = S_HALT;
        end else begin
          case (opcode)
            OP_BRA, OP_BNE: begin
              // BNE falls through to idle when the last flag write left Z set.
              if (opcode == OP_BRA || !flag_z) begin
                MuxBSel    = 2'b11;
                ARF_RegSel = 3'b100;
                ARF_FunSel = 2'b10;
              end
            end
            OP_IMM: begin
              MuxASel   = 2'b11;
              RF_FunSel = 3'b010;
              RF_RegSel = 4'b1000 >> rx;
            end
            OP_ADD: begin
              RF_OutASel = {1'b0, rx};
              RF_OutBSel = {1'b0, ry};
              MuxDSel    = 1'b0;
              ALU_FunSel = 5'b10100;
              ALU_WF     = 1'b1;
              state_d    = S_T3;
            end
            OP_STB: begin
              MuxBSel    = 2'b11;
              ARF_RegSel = 3'b010;
              ARF_FunSel = 2'b10;
              state_d    = S_T3;
            end
            default: ;
          endcase
        end
      end

      S_T3: begin
        state_d = S_T0;
        if (opcode == OP_ADD) begin
          // Flags were written at the T2 edge; writeback must not overwrite them.
          RF_OutASel = {1'b0, rx};
          RF_OutBSel = {1'b0, ry};
          MuxDSel    = 1'b0;
          ALU_FunSel = 5'b10100;
          MuxASel    = 2'b00;
          RF_FunSel  = 3'b010;
          RF_RegSel  = 4'b1000 >> rx;
        end else if (opcode == OP_STB) begin
          RF_OutASel  = {1'b0, rx};
          MuxDSel     = 1'b0;
          ALU_FunSel  = 5'b10000;
          MuxCSel     = 2'b00;
          ARF_OutDSel = 2'b10;
          Mem_CS      = 1'b0;
          Mem_WR      = 1'b1;
        end
      end

      S_HALT: begin
        Halted = 1'b1;
      end

      default: state_d = S_T0;
    endcase

    // Reset overrides decode so a reset mid-fetch never leaves memory selected.
    if (Reset) begin
      RF_OutASel  = 3'b000;
      RF_OutBSel  = 3'b000;
      RF_FunSel   = 3'b000;
      RF_RegSel   = 4'b0000;
      ALU_FunSel  = 5'b00000;
      ALU_WF      = 1'b0;
      ARF_OutDSel = 2'b00;
      ARF_FunSel  = 2'b00;
      ARF_RegSel  = 3'b000;
      IR_LH       = 1'b0;
      IR_Write    = 1'b0;
      Mem_WR      = 1'b0;
      Mem_CS      = 1'b1;
      MuxASel     = 2'b00;
      MuxBSel     = 2'b00;
      MuxCSel     = 2'b00;
      MuxDSel     = 1'b0;
      Halted      = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each queued vector carries the
// inputs for one cycle and the complete expected output snapshot.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] IROut = 16'h0000;
  logic [3:0]  FlagsOut = 4'b0000;

  logic [2:0] RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0] RF_RegSel, RF_ScrSel;
  logic [4:0] ALU_FunSel;
  logic       ALU_WF;
  logic [1:0] ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [2:0] ARF_RegSel;
  logic       IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [1:0] MuxASel, MuxBSel, MuxCSel;
  logic       MuxDSel;
  logic [1:0] DR_FunSel;
  logic       DR_E;
  logic [2:0] SeqState;
  logic       Halted;

  typedef struct packed {
    logic [2:0] seq_state;
    logic       halted;
    logic [2:0] rf_a, rf_b, rf_fun;
    logic [3:0] rf_reg, rf_scr;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [1:0] arf_c, arf_d, arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh, ir_write, mem_wr, mem_cs;
    logic [1:0] mux_a, mux_b, mux_c;
    logic       mux_d;
    logic [1:0] dr_fun;
    logic       dr_e;
  } out_t;

  typedef struct {
    logic        rst;
    logic [15:0] ir;
    logic [3:0]  flags;
    out_t        exp;
  } item_t;

  out_t  got;
  item_t sb[$];
  int    vectors = 0;
  int    miscompares = 0;

  assign got = {SeqState, Halted, RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel,
                RF_ScrSel, ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
                ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxASel, MuxBSel,
                MuxCSel, MuxDSel, DR_FunSel, DR_E};

  control_sequencer #(.HALT_OPCODE(6'h3F)) dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .FlagsOut(FlagsOut),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
    .ALU_WF(ALU_WF), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
    .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel),
    .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .MuxDSel(MuxDSel),
    .DR_FunSel(DR_FunSel), .DR_E(DR_E), .SeqState(SeqState), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  function automatic out_t idle_v(logic [2:0] s);
    out_t e;
    e = '0;
    e.seq_state = s;
    e.mem_cs = 1'b1;
    return e;
  endfunction

  function automatic out_t fetch_v(logic [2:0] s, logic lh);
    out_t e;
    e = idle_v(s);
    e.mem_cs   = 1'b0;
    e.ir_write = 1'b1;
    e.ir_lh    = lh;
    e.arf_reg  = 3'b100;
    e.arf_fun  = 2'b01;
    return e;
  endfunction

  function automatic void push(logic rst, logic [15:0] ir, logic [3:0] fl, out_t e);
    item_t it;
    it.rst = rst;
    it.ir = ir;
    it.flags = fl;
    it.exp = e;
    sb.push_back(it);
  endfunction

  task automatic test_reset();
    item_t it;
    int n = 0;
    push(1'b1, 16'h2000, 4'h0, idle_v(3'd0));
    push(1'b0, 16'h2000, 4'h0, fetch_v(3'd0, 1'b0));
    push(1'b0, 16'h2000, 4'h0, fetch_v(3'd1, 1'b1));
    push(1'b1, 16'h2000, 4'h0, idle_v(3'd0));
    push(1'b0, 16'h2000, 4'h0, fetch_v(3'd0, 1'b0));
    push(1'b0, 16'h2000, 4'h0, fetch_v(3'd1, 1'b1));
    push(1'b0, 16'h2000, 4'h0, idle_v(3'd2));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      Reset = it.rst; IROut = it.ir; FlagsOut = it.flags;
      #1;
      vectors++;
      if (got !== it.exp) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %h expected %h", n, got, it.exp);
      end
      n++;
    end
  endtask

  task automatic test_imm();
    item_t it;
    out_t e;
    int n = 0;
    push(1'b0, 16'h0905, 4'h0, fetch_v(3'd0, 1'b0));
    push(1'b0, 16'h0905, 4'h0, fetch_v(3'd1, 1'b1));
    e = idle_v(3'd2); e.mux_a = 2'b11; e.rf_fun = 3'b010; e.rf_reg = 4'b0100;
    push(1'b0, 16'h0905, 4'h0, e);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      Reset = it.rst; IROut = it.ir; FlagsOut = it.flags;
      #1;
      vectors++;
      if (got !== it.exp) begin
        miscompares++;
        $display("FAIL imm[%0d]: got %h expected %h", n, got, it.exp);
      end
      n++;
    end
  endtask

  task automatic test_bne();
    item_t it;
    out_t e;
    int n = 0;
    push(1'b0, 16'h0412, 4'b1000, fetch_v(3'd0, 1'b0));
    push(1'b0, 16'h0412, 4'b1000, fetch_v(3'd1, 1'b1));
    push(1'b0, 16'h0412, 4'b1000, idle_v(3'd2));
    push(1'b0, 16'h0412, 4'b0000, fetch_v(3'd0, 1'b0));
    push(1'b0, 16'h0412, 4'b0000, fetch_v(3'd1, 1'b1));
    e = idle_v(3'd2); e.mux_b = 2'b11; e.arf_reg = 3'b100; e.arf_fun = 2'b10;
    push(1'b0, 16'h0412, 4'b0000, e);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      Reset = it.rst; IROut = it.ir; FlagsOut = it.flags;
      #1;
      vectors++;
      if (got !== it.exp) begin
        miscompares++;
        $display("FAIL bne[%0d]: got %h expected %h", n, got, it.exp);
      end
      n++;
    end
  endtask

  task automatic test_add();
    item_t it;
    out_t e;
    int n = 0;
    push(1'b0, 16'h0E03, 4'h0, fetch_v(3'd0, 1'b0));
    push(1'b0, 16'h0E03, 4'h0, fetch_v(3'd1, 1'b1));
    e = idle_v(3'd2); e.rf_a = 3'b010; e.rf_b = 3'b011; e.alu_fun = 5'b10100; e.alu_wf = 1'b1;
    push(1'b0, 16'h0E03, 4'h0, e);
    e = idle_v(3'd3); e.rf_a = 3'b010; e.rf_b = 3'b011; e.alu_fun = 5'b10100;
    e.rf_fun = 3'b010; e.rf_reg = 4'b0010;
    push(1'b0, 16'h0E03, 4'h0, e);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      Reset = it.rst; IROut = it.ir; FlagsOut = it.flags;
      #1;
      vectors++;
      if (got !== it.exp) begin
        miscompares++;
        $display("FAIL add[%0d]: got %h expected %h", n, got, it.exp);
      end
      n++;
    end
  endtask

  task automatic test_stb();
    item_t it;
    out_t e;
    int n = 0;
    push(1'b0, 16'h1140, 4'h0, fetch_v(3'd0, 1'b0));
    push(1'b0, 16'h1140, 4'h0, fetch_v(3'd1, 1'b1));
    e = idle_v(3'd2); e.arf_reg = 3'b010; e.arf_fun = 2'b10; e.mux_b = 2'b11;
    push(1'b0, 16'h1140, 4'h0, e);
    e = idle_v(3'd3); e.arf_d = 2'b10; e.mem_cs = 1'b0; e.mem_wr = 1'b1;
    e.rf_a = 3'b001; e.alu_fun = 5'b10000;
    push(1'b0, 16'h1140, 4'h0, e);
    // A following NOP confirms the return to T0 and the 3-cycle NOP length.
    push(1'b0, 16'h2000, 4'h0, fetch_v(3'd0, 1'b0));
    push(1'b0, 16'h2000, 4'h0, fetch_v(3'd1, 1'b1));
    push(1'b0, 16'h2000, 4'h0, idle_v(3'd2));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      Reset = it.rst; IROut = it.ir; FlagsOut = it.flags;
      #1;
      vectors++;
      if (got !== it.exp) begin
        miscompares++;
        $display("FAIL stb[%0d]: got %h expected %h", n, got, it.exp);
      end
      n++;
    end
  endtask

  task automatic test_halt();
    item_t it;
    out_t e;
    int n = 0;
    push(1'b0, 16'hFC00, 4'h0, fetch_v(3'd0, 1'b0));
    push(1'b0, 16'hFC00, 4'h0, fetch_v(3'd1, 1'b1));
    push(1'b0, 16'hFC00, 4'h0, idle_v(3'd2));
    e = idle_v(3'd4); e.halted = 1'b1;
    for (int i = 0; i < 20; i++) push(1'b0, 16'hFC00, 4'h0, e);
    push(1'b1, 16'hFC00, 4'h0, idle_v(3'd0));
    push(1'b0, 16'hFC00, 4'h0, fetch_v(3'd0, 1'b0));
    push(1'b0, 16'hFC00, 4'h0, fetch_v(3'd1, 1'b1));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      Reset = it.rst; IROut = it.ir; FlagsOut = it.flags;
      #1;
      vectors++;
      if (got !== it.exp) begin
        miscompares++;
        $display("FAIL halt[%0d]: got %h expected %h", n, got, it.exp);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_bne();
    test_add();
    test_stb();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
